// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for the RV32I core.
// FETCH -> DECODE -> EXEC -> [MEM] -> WB, with a sticky TRAP state.
// Optional build macro CTRL_SEQ_TIMEOUT_EN adds a bus-wait watchdog that
// traps with cause 3 after TIMEOUT_CYCLES consecutive no-ack cycles.
//
// Handshake: a request (if_req / dmem_req) is decoded from the registered
// state only, stays high every cycle until its ack is sampled on a rising
// edge, and drops in the cycle after that ack; acks outside FETCH/MEM are
// ignored.
module ctrl_seq #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic        if_req,
    input  logic        if_ack,
    input  logic [31:0] if_instr,
    output logic [31:0] ir,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_branch,
    input  logic        dec_jalr,
    input  logic        dec_jal,
    input  logic        dec_lui,
    input  logic        dec_auipc,
    input  logic        dec_op_imm,
    input  logic        dec_op,
    input  logic        dec_system,
    input  logic        br_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic        halt,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] cause_d;
    logic       timeout_hit;
    logic       any_class;
    logic       writes_rd;

    assign state = state_q;

    assign any_class = dec_load | dec_store | dec_branch | dec_jalr | dec_jal |
                       dec_lui | dec_auipc | dec_op_imm | dec_op | dec_system;

    // Classes that produce a register result; x0 writes are suppressed.
    assign writes_rd = (dec_load | dec_jal | dec_jalr | dec_lui | dec_auipc |
                        dec_op_imm | dec_op) && (ir[11:7] != 5'd0);

`ifdef CTRL_SEQ_TIMEOUT_EN
    logic [31:0] wait_cnt;

    // Consecutive no-ack cycles in FETCH/MEM; any other cycle clears it,
    // so it always starts from zero on entry to a waiting state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 32'd0;
        end else if ((state_q == S_FETCH && !if_ack) ||
                     (state_q == S_MEM && !dmem_ack)) begin
            wait_cnt <= wait_cnt + 32'd1;
        end else begin
            wait_cnt <= 32'd0;
        end
    end

    // This cycle is the TIMEOUT_CYCLES-th wait cycle if it also lacks an ack.
    assign timeout_hit = (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state and strobe decode; outputs depend on the registered state.
    always_comb begin
        state_d  = state_q;
        cause_d  = 2'd0;
        if_req   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        wb_sel   = 2'd0;
        case (state_q)
            S_FETCH: begin
                if_req = 1'b1;
                if (if_ack) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end
            end
            S_DECODE: begin
                if (!any_class || ir[1:0] != 2'b11) begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end else if (dec_system) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (dec_load || dec_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_store;
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end
            end
            S_WB: begin
                pc_we   = 1'b1;
                rf_we   = writes_rd;
                state_d = S_FETCH;
                if (dec_load) begin
                    wb_sel = 2'd1;
                end else if (dec_jal || dec_jalr) begin
                    wb_sel = 2'd2;
                end
                if (dec_jalr) begin
                    pc_sel = 2'd2;
                end else if (dec_jal || (dec_branch && br_taken)) begin
                    pc_sel = 2'd1;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
                cause_d = 2'd1;
            end
        endcase
    end

    // State, instruction register, trap status and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            ir         <= 32'd0;
            halt       <= 1'b0;
            trap_cause <= 2'd0;
            instret    <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && if_ack) begin
                ir <= if_instr;
            end
            if (state_d == S_TRAP && state_q != S_TRAP) begin
                halt       <= 1'b1;
                trap_cause <= cause_d;
            end
            if (state_q == S_WB) begin
                instret <= instret + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: table-driven directed bench for ctrl_seq, plus hand-written
// sequences for reset mid-access and (with CTRL_SEQ_TIMEOUT_EN) the watchdog.
module tb_ctrl_seq;

    // Class flag bit positions in cls.
    localparam logic [9:0] F_LOAD   = 10'b1000000000;
    localparam logic [9:0] F_STORE  = 10'b0100000000;
    localparam logic [9:0] F_BRANCH = 10'b0010000000;
    localparam logic [9:0] F_JALR   = 10'b0001000000;
    localparam logic [9:0] F_JAL    = 10'b0000100000;
    localparam logic [9:0] F_LUI    = 10'b0000010000;
    localparam logic [9:0] F_AUIPC  = 10'b0000001000;
    localparam logic [9:0] F_OPIMM  = 10'b0000000100;
    localparam logic [9:0] F_OP     = 10'b0000000010;
    localparam logic [9:0] F_SYSTEM = 10'b0000000001;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  flags;
        logic        br;
        int          fwait;
        int          mwait;
        logic        rf;
        logic [1:0]  wb;
        logic [1:0]  pc;
        logic [1:0]  cause;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req;
    logic        if_ack = 1'b0;
    logic [31:0] if_instr = 32'd0;
    logic [31:0] ir;
    logic [9:0]  cls = 10'd0;
    logic        br_taken = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        rf_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    logic        halt;
    logic [1:0]  trap_cause;
    logic [31:0] instret;
    logic [2:0]  state;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_instret = 32'd0;
    vec_t        vecs[14];

    ctrl_seq #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_ack     (if_ack),
        .if_instr   (if_instr),
        .ir         (ir),
        .dec_load   (cls[9]),
        .dec_store  (cls[8]),
        .dec_branch (cls[7]),
        .dec_jalr   (cls[6]),
        .dec_jal    (cls[5]),
        .dec_lui    (cls[4]),
        .dec_auipc  (cls[3]),
        .dec_op_imm (cls[2]),
        .dec_op     (cls[1]),
        .dec_system (cls[0]),
        .br_taken   (br_taken),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .rf_we      (rf_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .wb_sel     (wb_sel),
        .halt       (halt),
        .trap_cause (trap_cause),
        .instret    (instret),
        .state      (state)
    );

    // Clock and run-time guard.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_instret = 32'd0;
        #1;
    endtask

    // Walk one instruction through the sequencer, checking every cycle.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        logic  is_mem;
        t = $sformatf("v%0d", idx);
        is_mem = (v.flags & (F_LOAD | F_STORE)) != 10'd0;
        cls = 10'd0;
        br_taken = 1'b0;
        for (int k = 0; k < v.fwait; k++) begin
            chk({t, " fetch_wait state"}, 32'(state), 32'd0);
            chk({t, " fetch_wait if_req"}, 32'(if_req), 32'd1);
            tick;
        end
        if_ack = 1'b1;
        if_instr = v.instr;
        #1;
        chk({t, " fetch if_req"}, 32'(if_req), 32'd1);
        tick;
        if_ack = 1'b0;
        if_instr = 32'hDEADBEEF;
        cls = v.flags;
        #1;
        chk({t, " decode state"}, 32'(state), 32'd1);
        chk({t, " decode ir"}, ir, v.instr);
        chk({t, " decode if_req"}, 32'(if_req), 32'd0);
        chk({t, " decode pc_we"}, 32'(pc_we), 32'd0);
        tick;
        if (v.cause != 2'd0) begin
            chk({t, " trap state"}, 32'(state), 32'd5);
            chk({t, " trap halt"}, 32'(halt), 32'd1);
            chk({t, " trap cause"}, 32'(trap_cause), 32'(v.cause));
            chk({t, " trap instret"}, instret, exp_instret);
            if_ack = 1'b1;
            dmem_ack = 1'b1;
            tick;
            tick;
            if_ack = 1'b0;
            dmem_ack = 1'b0;
            #1;
            chk({t, " trap hold state"}, 32'(state), 32'd5);
            chk({t, " trap hold strobes"}, {pc_we, rf_we, if_req, dmem_req}, 32'd0);
            chk({t, " trap hold cause"}, 32'(trap_cause), 32'(v.cause));
            chk({t, " trap hold instret"}, instret, exp_instret);
            do_reset;
            chk({t, " post-trap state"}, 32'(state), 32'd0);
            chk({t, " post-trap halt"}, 32'(halt), 32'd0);
            chk({t, " post-trap cause"}, 32'(trap_cause), 32'd0);
            chk({t, " post-trap instret"}, instret, 32'd0);
            chk({t, " post-trap if_req"}, 32'(if_req), 32'd1);
            return;
        end
        // Spurious acks in EXEC must be ignored.
        if_ack = 1'b1;
        dmem_ack = 1'b1;
        br_taken = v.br;
        #1;
        chk({t, " exec state"}, 32'(state), 32'd2);
        chk({t, " exec strobes"}, {pc_we, rf_we, if_req, dmem_req}, 32'd0);
        tick;
        if_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        if (is_mem) begin
            for (int k = 0; k <= v.mwait; k++) begin
                chk({t, " mem state"}, 32'(state), 32'd3);
                chk({t, " mem dmem_req"}, 32'(dmem_req), 32'd1);
                chk({t, " mem dmem_we"}, 32'(dmem_we), 32'((v.flags & F_STORE) != 10'd0));
                if (k == v.mwait) dmem_ack = 1'b1;
                tick;
                dmem_ack = 1'b0;
                #1;
            end
        end
        chk({t, " wb state"}, 32'(state), 32'd4);
        chk({t, " wb pc_we"}, 32'(pc_we), 32'd1);
        chk({t, " wb rf_we"}, 32'(rf_we), 32'(v.rf));
        chk({t, " wb wb_sel"}, 32'(wb_sel), 32'(v.wb));
        chk({t, " wb pc_sel"}, 32'(pc_sel), 32'(v.pc));
        chk({t, " wb reqs"}, {if_req, dmem_req}, 32'd0);
        tick;
        exp_instret = exp_instret + 32'd1;
        br_taken = 1'b0;
        #1;
        chk({t, " next state"}, 32'(state), 32'd0);
        chk({t, " next strobes"}, {pc_we, rf_we}, 32'd0);
        chk({t, " next instret"}, instret, exp_instret);
        chk({t, " next if_req"}, 32'(if_req), 32'd1);
    endtask

    // Main sequence: reset, vector table, hand-written corner cases, report.
    initial begin
        //           instr          flags     br   fw mw rf    wb    pc    cause
        vecs[0]  = '{32'h00500093, F_OPIMM,  1'b0, 0, 0, 1'b1, 2'd0, 2'd0, 2'd0};
        vecs[1]  = '{32'h0000A103, F_LOAD,   1'b0, 0, 3, 1'b1, 2'd1, 2'd0, 2'd0};
        vecs[2]  = '{32'h0020A023, F_STORE,  1'b0, 1, 0, 1'b0, 2'd0, 2'd0, 2'd0};
        vecs[3]  = '{32'h00000013, F_OPIMM,  1'b0, 0, 0, 1'b0, 2'd0, 2'd0, 2'd0};
        vecs[4]  = '{32'h00208463, F_BRANCH, 1'b1, 0, 0, 1'b0, 2'd0, 2'd1, 2'd0};
        vecs[5]  = '{32'h00208463, F_BRANCH, 1'b0, 2, 0, 1'b0, 2'd0, 2'd0, 2'd0};
        vecs[6]  = '{32'h000080E7, F_JALR,   1'b0, 0, 0, 1'b1, 2'd2, 2'd2, 2'd0};
        vecs[7]  = '{32'h008000EF, F_JAL,    1'b0, 0, 0, 1'b1, 2'd2, 2'd1, 2'd0};
        vecs[8]  = '{32'h123452B7, F_LUI,    1'b0, 0, 0, 1'b1, 2'd0, 2'd0, 2'd0};
        vecs[9]  = '{32'h002081B3, F_OP,     1'b0, 0, 1, 1'b1, 2'd0, 2'd0, 2'd0};
        vecs[10] = '{32'h00000317, F_AUIPC,  1'b0, 0, 0, 1'b1, 2'd0, 2'd0, 2'd0};
        vecs[11] = '{32'h00000000, 10'd0,    1'b0, 0, 0, 1'b0, 2'd0, 2'd0, 2'd1};
        vecs[12] = '{32'h00000073, F_SYSTEM, 1'b0, 0, 0, 1'b0, 2'd0, 2'd0, 2'd2};
        vecs[13] = '{32'h00500090, F_OPIMM,  1'b0, 1, 0, 1'b0, 2'd0, 2'd0, 2'd1};

        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("reset state", 32'(state), 32'd0);
        chk("reset if_req", 32'(if_req), 32'd1);
        chk("reset ir", ir, 32'd0);
        chk("reset halt", 32'(halt), 32'd0);
        chk("reset trap_cause", 32'(trap_cause), 32'd0);
        chk("reset instret", instret, 32'd0);
        chk("reset strobes", {dmem_req, rf_we, pc_we}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], i);
        end

        // Retire two instructions, then reset in the middle of a load.
        run_vec(vecs[0], 100);
        run_vec(vecs[3], 101);
        if_ack = 1'b1;
        if_instr = 32'h0000A103;
        tick;
        if_ack = 1'b0;
        cls = F_LOAD;
        tick;
        tick;
        chk("midmem state", 32'(state), 32'd3);
        chk("midmem dmem_req", 32'(dmem_req), 32'd1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        cls = 10'd0;
        exp_instret = 32'd0;
        #1;
        chk("midmem rst state", 32'(state), 32'd0);
        chk("midmem rst strobes", {dmem_req, pc_we, rf_we}, 32'd0);
        chk("midmem rst instret", instret, 32'd0);
        chk("midmem rst ir", ir, 32'd0);
        chk("midmem rst if_req", 32'(if_req), 32'd1);

`ifdef CTRL_SEQ_TIMEOUT_EN
        // Never ack: trap with cause 3 after the 4th wait cycle.
        for (int k = 0; k < 4; k++) begin
            chk("timeout waiting state", 32'(state), 32'd0);
            tick;
        end
        chk("timeout state", 32'(state), 32'd5);
        chk("timeout cause", 32'(trap_cause), 32'd3);
        chk("timeout halt", 32'(halt), 32'd1);
        do_reset;
        // Ack in the expiry cycle wins.
        tick;
        tick;
        tick;
        if_ack = 1'b1;
        if_instr = 32'h00500093;
        tick;
        if_ack = 1'b0;
        #1;
        chk("timeout ack-wins state", 32'(state), 32'd1);
        chk("timeout ack-wins cause", 32'(trap_cause), 32'd0);
        do_reset;
`else
        // Without the watchdog a fetch waits indefinitely.
        for (int k = 0; k < 20; k++) tick;
        chk("nowatchdog state", 32'(state), 32'd0);
        chk("nowatchdog if_req", 32'(if_req), 32'd1);
        chk("nowatchdog halt", 32'(halt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
